// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetch: one outstanding memory read at a time, results buffered
// with their PCs in a small FIFO that the decoder pops; a redirect flushes and restarts.
module inst_fetch_queue #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  input  logic        jump_valid,
  input  logic [31:0] jump_pc,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        queue_full
);

  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(QUEUE_DEPTH);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic            discard_q, discard_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic [31:0] inst_mem [QUEUE_DEPTH];
  logic [31:0] pc_mem   [QUEUE_DEPTH];

  logic flush;
  logic push;
  logic pop;

  assign out_valid  = (count_q != '0) & ~jump_valid;
  assign out_inst   = inst_mem[head_q];
  assign out_pc     = pc_mem[head_q];
  assign queue_full = (count_q == CntMax);
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign pop        = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    discard_d  = discard_q;
    flush      = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (jump_valid) begin
          pc_d  = jump_pc;
          flush = 1'b1;
        end else if (count_q < CntMax) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          req_pc_d   = pc_q;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (mem_done) begin
          mem_req_d = 1'b0;
          discard_d = 1'b0;
          state_d   = StIdle;
          if (jump_valid) begin
            pc_d  = jump_pc;
            flush = 1'b1;
          end else if (!discard_q) begin
            push = 1'b1;
            pc_d = req_pc_q + 32'd4;
          end
        end else if (jump_valid) begin
          // The read in flight cannot be cancelled; remember to drop its data.
          pc_d      = jump_pc;
          flush     = 1'b1;
          discard_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + 1'b1;
      if (push) tail_d = tail_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      discard_q  <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      discard_q  <= discard_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem[tail_q] <= mem_data;
      pc_mem[tail_q]   <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised and directed bench for inst_fetch_queue against a queue-level model of the
// fetch stream, with a latency-programmable memory stand-in.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done = 1'b0;
  logic [31:0] mem_data = '0;
  logic        jump_valid = 1'b0;
  logic [31:0] jump_pc = '0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic        queue_full;

  int checks = 0;
  int errors = 0;

  // Model: expected queue contents (PCs), next expected fetch address, memory state.
  logic [31:0] m_q[$];
  logic [31:0] pop_log[$];
  logic [31:0] m_next_pc = RST_PC;
  logic        m_drop = 1'b0;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_a = '0;
  int          mem_cnt = 0;
  int          lat = 2;

  inst_fetch_queue #(
    .QUEUE_DEPTH(DEPTH),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_done  (mem_done),
    .mem_data  (mem_data),
    .jump_valid(jump_valid),
    .jump_pc   (jump_pc),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .queue_full(queue_full)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA500_0013;
  endfunction

  // One clock: drive inputs at negedge, check outputs, advance the model at posedge.
  task automatic cycle(input logic rst, input logic rdy, input logic jmp,
                       input logic [31:0] jpc);
    logic done;
    logic exp_v;
    logic take;
    @(negedge clk_in);
    done = 1'b0;
    if (!rst) begin
      if (!mem_busy && mem_req) begin
        mem_busy = 1'b1;
        mem_cnt  = 0;
        mem_a    = mem_addr;
        checks++;
        if (mem_addr !== m_next_pc) begin
          errors++;
          $display("FAIL req_addr got=%h exp=%h", mem_addr, m_next_pc);
        end
        checks++;
        if (m_q.size() >= DEPTH) begin
          errors++;
          $display("FAIL issue_when_full got=req exp=no_req size=%0d", m_q.size());
        end
      end else if (mem_busy) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== mem_a) begin
          errors++;
          $display("FAIL req_stable got=%b/%h exp=1/%h", mem_req, mem_addr, mem_a);
        end
      end
      if (mem_busy) begin
        mem_cnt++;
        if (mem_cnt >= lat) done = 1'b1;
      end
    end
    rst_in     = rst;
    mem_done   = done;
    mem_data   = done ? inst_of(mem_a) : $urandom();
    out_ready  = rdy;
    jump_valid = jmp;
    jump_pc    = jpc;
    #1;
    if (!rst) begin
      exp_v = (m_q.size() != 0) && !jmp;
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL out_valid got=%b exp=%b", out_valid, exp_v);
      end
      checks++;
      if (queue_full !== (m_q.size() == DEPTH)) begin
        errors++;
        $display("FAIL queue_full got=%b exp=%b", queue_full, m_q.size() == DEPTH);
      end
      if (exp_v) begin
        checks++;
        if (out_pc !== m_q[0] || out_inst !== inst_of(m_q[0])) begin
          errors++;
          $display("FAIL head got=%h/%h exp=%h/%h", out_pc, out_inst, m_q[0], inst_of(m_q[0]));
        end
      end
    end
    take = !rst && exp_v && rdy;
    if (take) pop_log.push_back(m_q[0]);
    @(posedge clk_in);
    if (rst) begin
      m_q.delete();
      m_next_pc = RST_PC;
      m_drop    = 1'b0;
      mem_busy  = 1'b0;
    end else if (jmp) begin
      m_q.delete();
      m_next_pc = jpc;
      if (done) begin
        mem_busy = 1'b0;
        m_drop   = 1'b0;
      end else if (mem_busy) begin
        m_drop = 1'b1;
      end
    end else begin
      if (take) void'(m_q.pop_front());
      if (done) begin
        mem_busy = 1'b0;
        if (!m_drop) begin
          m_q.push_back(mem_a);
          m_next_pc = mem_a + 32'd4;
        end
        m_drop = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem got=%b/%h exp=0/0", mem_req, mem_addr);
    end
    checks++;
    if (out_valid !== 1'b0 || queue_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_queue got=%b/%b exp=0/0", out_valid, queue_full);
    end
  endtask

  task automatic test_fill();
    lat = 2;
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 1'b0, '0);
    #1;
    checks++;
    if (queue_full !== 1'b1 || out_valid !== 1'b1 || out_pc !== RST_PC) begin
      errors++;
      $display("FAIL fill got=%b/%b/%h exp=1/1/%h", queue_full, out_valid, out_pc, RST_PC);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      #1;
      checks++;
      if (mem_req !== 1'b0) begin
        errors++;
        $display("FAIL full_no_req got=%b exp=0", mem_req);
      end
    end
  endtask

  task automatic test_pop_one();
    cycle(1'b0, 1'b1, 1'b0, '0);
    #1;
    checks++;
    if (queue_full !== 1'b0 || out_pc !== 32'h4 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL pop_one got=%b/%h/%b exp=0/00000004/0", queue_full, out_pc, mem_req);
    end
    cycle(1'b0, 1'b0, 1'b0, '0);
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
      errors++;
      $display("FAIL refill_req got=%b/%h exp=1/00000010", mem_req, mem_addr);
    end
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic test_steady();
    do_reset();
    lat = 1;
    pop_log.delete();
    for (int i = 0; i < 60; i++) cycle(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (pop_log.size() < 10) begin
      errors++;
      $display("FAIL steady_pops got=%0d exp>=10", pop_log.size());
    end
    for (int i = 0; i < pop_log.size(); i++) begin
      checks++;
      if (pop_log[i] !== RST_PC + 32'(4 * i)) begin
        errors++;
        $display("FAIL steady_seq got=%h exp=%h", pop_log[i], RST_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_jump_wait();
    logic found;
    do_reset();
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      #1;
      found = mem_req && mem_addr == 32'h8;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL jw_reach got=timeout exp=req_8");
    end
    cycle(1'b0, 1'b0, 1'b1, 32'h100);
    #1;
    checks++;
    if (out_valid !== 1'b0 || queue_full !== 1'b0) begin
      errors++;
      $display("FAIL jw_flush got=%b/%b exp=0/0", out_valid, queue_full);
    end
    pop_log.delete();
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (pop_log.size() == 0 || pop_log[0] !== 32'h100) begin
      errors++;
      $display("FAIL jw_first got=%h exp=00000100", pop_log.size() ? pop_log[0] : 32'hx);
    end
  endtask

  task automatic test_jump_done_pop();
    logic found;
    do_reset();
    lat = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      found = m_q.size() > 0 && mem_busy && mem_cnt == lat - 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL jd_reach got=timeout exp=setup");
    end
    cycle(1'b0, 1'b1, 1'b1, 32'h200);
    #1;
    checks++;
    if (out_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL jd_flush got=%b/%b exp=0/0", out_valid, mem_req);
    end
    cycle(1'b0, 1'b0, 1'b0, '0);
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      errors++;
      $display("FAIL jd_req got=%b/%h exp=1/00000200", mem_req, mem_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic found;
    do_reset();
    lat = 4;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      found = mem_busy && m_q.size() > 0;
    end
    cycle(1'b1, 1'b0, 1'b0, '0);
    #1;
    checks++;
    if (!found || mem_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait got=%b/%b/%b exp=1/0/0", found, mem_req, out_valid);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      #1;
      found = mem_req;
    end
    checks++;
    if (!found || mem_addr !== RST_PC) begin
      errors++;
      $display("FAIL rst_restart got=%b/%h exp=1/%h", found, mem_addr, RST_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] jpc;
    logic        rdy;
    logic        jmp;
    logic        rst;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (!mem_busy) lat = $urandom_range(1, 4);
      r   = $urandom();
      jpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : {r[31:2], 2'b00};
      rdy = ($urandom_range(0, 2) != 0);
      jmp = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 200) == 0);
      cycle(rst, rdy, jmp, jpc);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_pop_one();
    test_steady();
    test_jump_wait();
    test_jump_done_pop();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Instruction fetch stage directly upstream of the instruction decoder. Holds the PC and issues one 32-bit word fetch at a time to the memory controller. Buffers returned instructions with their PCs in a small FIFO; the decoder consumes from the head via a valid/ready pop. Sequential fetch only, with no prediction; a redirect from the back end flushes the queue and restarts fetch at a new PC.

Parameters:
QUEUE_DEPTH, 4, number of queue entries; power of two, minimum 2
RESET_PC, 32'h0, PC loaded on reset

Ports:
clk_in  input  1  clock; all state updates on the rising edge
rst_in  input  1  reset; synchronous, active-high
mem_req  output  1  fetch request, held high while a fetch is outstanding
mem_addr  output  32  byte address of the outstanding fetch
mem_done  input  1  one-cycle pulse: mem_data is valid this cycle
mem_data  input  32  fetched instruction word
jump_valid  input  1  redirect pulse: flush and restart at jump_pc
jump_pc  input  32  redirect target
out_valid  output  1  queue head is valid
out_inst  output  32  instruction at the queue head, to the decoder
out_pc  output  32  PC of the queue head
out_ready  input  1  decoder pops the head this cycle when out_valid=1
queue_full  output  1  count == QUEUE_DEPTH

Behaviour:
- Reset values (registered, applied when rst_in=1 at a clock edge):
  - state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=0.
  - head=tail=count=0, discard=0.
- Output derivation:
  - out_valid = (count!=0) & ~jump_valid.
  - out_inst and out_pc are read combinationally from the head entry.
  - queue_full is combinational from count.
- FSM state IDLE:
  - If jump_valid: pc<=jump_pc; clear the queue; stay IDLE.
  - Else if count<QUEUE_DEPTH: mem_req<=1, mem_addr<=pc, req_pc<=pc, state<=WAIT.
  - Else: stay IDLE with mem_req=0.
- FSM state WAIT:
  - mem_req and mem_addr stay stable until the mem_done cycle.
  - On mem_done with no flush pending and jump_valid=0:
    - push {req_pc, mem_data} at tail.
    - pc<=req_pc+4 (mod 2^32).
    - mem_req<=0, state<=IDLE.
  - On jump_valid without mem_done: pc<=jump_pc; clear the queue; discard<=1; remain in WAIT. The outstanding memory transaction cannot be cancelled.
  - On mem_done with discard=1 or jump_valid=1:
    - drop the data; no push.
    - discard<=0, mem_req<=0, state<=IDLE.
    - If jump_valid is also set this cycle, pc<=jump_pc.
- Latency: one fetch in flight at most. With a memory latency of L cycles, the request-to-request interval is L+2 cycles.
  - The pushed entry is visible on out_valid the cycle after mem_done.
- Pop: when out_valid & out_ready, head advances and count decrements.
  - A simultaneous push and pop leaves count unchanged.
  - head and tail wrap modulo QUEUE_DEPTH.
- Full: no new request issues while count==QUEUE_DEPTH.
  - Overflow is impossible: a request issues only when count<DEPTH, and only that request can push.
- Empty: out_valid=0. out_inst and out_pc are don't-care.
- jump_valid has priority over pop, push, and issue in the same cycle.
  - The pop is ignored.
  - The queue is empty on the next cycle.
- Reset mid-WAIT: return to the reset state immediately. A mem_done arriving later while IDLE is ignored; the memory controller is reset by the same rst_in.
- mem_done in IDLE is ignored.

Test Plan:
- Reset, RESET_PC=0, memory latency 2 → first mem_req with addr 0x0. After 4 fetches of words 0x00000013… the queue holds PCs 0,4,8,C; queue_full=1; mem_req stays 0 while out_ready=0.
- Full queue, then out_ready=1 for one cycle → head PC 0 popped, count=3; a new request issues with addr 0x10 on the following edge.
- Steady-state pop every cycle with latency 1 → out_pc sequence 0,4,8,… with no duplicates or gaps; count never exceeds 1.
- jump_valid with jump_pc=0x100 during WAIT for addr 0x8 → queue empty next cycle; the 0x8 response is dropped; the next request has addr 0x100; out_pc=0x100 appears first.
- jump_valid in the same cycle as mem_done and out_ready → no push, pop ignored, queue empty, next mem_addr=jump_pc.
- rst_in asserted mid-WAIT → next cycle mem_req=0, out_valid=0; after release the fetch restarts at RESET_PC.
